// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback, stalling on mem_ready.
// Outputs are decoded from state (FETCH/MEMWR also use mem_ready); a stuck memory ends in ERROR until reset.
module multicycle_control #(
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] OP_R    = 6'b000000,
  parameter logic [OP_W-1:0] OP_ADDI = 6'b001100,
  parameter logic [OP_W-1:0] OP_SUBI = 6'b001101,
  parameter logic [OP_W-1:0] OP_SW   = 6'b010000,
  parameter logic [OP_W-1:0] OP_LW   = 6'b010001,
  parameter logic [OP_W-1:0] OP_BEQ  = 6'b010011,
  parameter logic [OP_W-1:0] OP_J    = 6'b011100,
  parameter int              TIMEOUT = 16,
  parameter int              CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  OP,
  input  logic             mem_ready,
  output logic [1:0]       ALU_OP,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem2reg,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADDR = 4'd2,  S_MEMRD = 4'd3,
    S_LWWB    = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC   = 4'd6,  S_RWB   = 4'd7,
    S_IEXEC   = 4'd8,  S_IWB    = 4'd9,  S_BRANCH  = 4'd10, S_JUMP  = 4'd11,
    S_ERROR   = 4'd12
  } state_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              berr_q, berr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              waiting, timeout_hit, retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      berr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      berr_q    <= berr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    ALU_OP        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem2reg       = 1'b0;
    state_d       = state_q;
    illegal_d     = illegal_q;
    berr_d        = berr_q;
    waiting       = 1'b0;
    retire        = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        waiting   = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (OP)
          OP_R:             state_d = S_REXEC;
          OP_ADDI, OP_SUBI: state_d = S_IEXEC;
          OP_LW, OP_SW:     state_d = S_MEMADDR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        waiting  = 1'b1;
        if (mem_ready) state_d = S_LWWB;
      end
      S_LWWB: begin
        reg_write = 1'b1;
        mem2reg   = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        waiting   = 1'b1;
        retire    = mem_ready;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        ALU_OP    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALU_OP    = (OP == OP_SUBI) ? 2'b01 : 2'b00;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        ALU_OP        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      // ERROR holds; unused encodings fall into it as well
      default: state_d = S_ERROR;
    endcase

    if (retire) state_d = S_FETCH;

    // A late mem_ready on the last allowed cycle still completes the access
    timeout_hit = waiting && !mem_ready && (TIMEOUT > 0) &&
                  (wait_q == WAIT_W'(TIMEOUT - 1));
    if (timeout_hit) begin
      state_d = S_ERROR;
      berr_d  = 1'b1;
    end

    wait_d = (waiting && !mem_ready && !timeout_hit) ? wait_q + 1'b1 : '0;
    cnt_d  = cnt_q + CNT_W'(retire);
  end

  assign instr_done  = retire;
  assign illegal_op  = illegal_q;
  assign bus_error   = berr_q;
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder.
- A Moore/Mealy FSM sequences each instruction over 3–5 states: fetch, decode, execute, memory, writeback.
- It drives the shared-ALU/shared-memory datapath and stalls on a variable-latency memory through a ready handshake.
- It adds a memory timeout, illegal-opcode detection and a retired-instruction counter.

Parameters:
- OP_W, 6, opcode width.
- OP_R, 6'b000000, R-type opcode.
- OP_ADDI, 6'b001100, add immediate.
- OP_SUBI, 6'b001101, sub immediate.
- OP_SW, 6'b010000, store.
- OP_LW, 6'b010001, load.
- OP_BEQ, 6'b010011, branch-equal.
- OP_J, 6'b011100, jump.
- TIMEOUT, 16, max wait cycles for mem_ready; 0 disables the timeout.
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- OP  in  OP_W  opcode field of the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- ALU_OP  out  2  00 add, 01 sub, 10 funct-decoded.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- iord  out  1  0=PC addresses memory, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target.
- reg_write  out  1  register file write.
- reg_dst  out  1  1=rd, 0=rt.
- mem2reg  out  1  1=MDR to register file.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  sticky; an unknown opcode was decoded.
- bus_error  out  1  sticky; memory timeout occurred.
- instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W.
- state  out  4  current state, for debug.

Behaviour:
- Reset: rst_n=0 at a clk edge gives state=FETCH(0), wait counter=0, illegal_op=0, bus_error=0, instr_count=0.
- Reset applies mid-instruction; the partially executed instruction is abandoned.
- Default values: all outputs not listed for a state are 0, including don't-care selects.
- State encoding: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, LWWB 4, MEMWR 5, REXEC 6, RWB 7, IEXEC 8, IWB 9, BRANCH 10, JUMP 11, ERROR 12.
- FETCH: mem_read=1, iord=0, alu_src_b=01, ALU_OP=00.
  - ir_write=pc_write=mem_ready (Mealy).
  - Advance to DECODE when mem_ready; otherwise hold.
- DECODE: alu_src_b=11, ALU_OP=00. Next state by OP:
  - R to REXEC.
  - ADDI/SUBI to IEXEC.
  - LW/SW to MEMADDR.
  - BEQ to BRANCH.
  - J to JUMP.
  - Any other value: set illegal_op, pulse instr_done=0, return to FETCH.
- MEMADDR: alu_src_a=1, alu_src_b=10, ALU_OP=00. Next is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then LWWB.
- LWWB: reg_write=1, reg_dst=0, mem2reg=1. Retire.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready, then retire.
- REXEC: alu_src_a=1, alu_src_b=00, ALU_OP=10. Then RWB.
- RWB: reg_write=1, reg_dst=1. Retire.
- IEXEC: alu_src_a=1, alu_src_b=10. ALU_OP=00 for ADDI, 01 for SUBI (OP re-sampled; IR is stable). Then IWB.
- IWB: reg_write=1, reg_dst=0. Retire.
- BRANCH: alu_src_a=1, alu_src_b=00, ALU_OP=01, pc_write_cond=1, pc_source=01. Retire.
- JUMP: pc_write=1, pc_source=10. Retire.
- Retire: next state is FETCH. instr_done=1 for that cycle. instr_count increments by 1 at the edge (modulo 2^CNT_W).
- Timeout:
  - The wait counter counts consecutive cycles in FETCH/MEMRD/MEMWR with mem_ready=0. It clears on leaving those states or when mem_ready=1.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with mem_ready still 0, the next state is ERROR and bus_error is set.
  - mem_ready=1 on that same cycle wins: normal advance, no error.
- ERROR: all control outputs 0. Held until reset.
- Latencies with zero-wait memory, FETCH inclusive: R/ADDI/SUBI 4 cycles, LW 5, SW 4, BEQ 3, J 3.

Test Plan:
- Reset then R-type: rst_n=0 for 2 cycles, OP=0, mem_ready=1.
  - state sequence 0,1,6,7,0.
  - ALU_OP=10 in state 6; reg_write=1, reg_dst=1 in state 7.
  - instr_done pulse on state 7; instr_count=1.
- LW with 3 wait cycles on the data read: OP=6'b010001, mem_ready low 3 cycles in MEMRD.
  - State 3 is held 4 cycles; mem_read=iord=1 throughout.
  - LWWB asserts mem2reg=1 and reg_write=1. Total 8 cycles.
- ADDI then SUBI back-to-back: ALU_OP=00 in IEXEC for 001100, then ALU_OP=01 for 001101. instr_count=2.
- BEQ then J: BEQ gives pc_write_cond=1, pc_source=01 in state 10; J gives pc_write=1, pc_source=10 in state 11. 3 cycles each.
- Illegal opcode: OP=6'b111111 returns to FETCH after DECODE. illegal_op=1 stays set, instr_count unchanged.
- Timeout and reset: TIMEOUT=16, mem_ready=0 held in FETCH.
  - Cycle 16 enters ERROR with bus_error=1; outputs stay 0 for 50 cycles.
  - rst_n=0 clears to FETCH with bus_error=0.
  - A second run with mem_ready=1 on the 16th wait cycle advances normally with no error.
